// File: rtl/gcd_job_sequencer.sv
// Job sequencer for the top_gcd core: an input FIFO, one job in flight, in-order results.
// Define GCD_SEQ_TIMEOUT_EN to abort a job with res_err when the core never reports done.
`timescale 1ns/1ps
module gcd_job_sequencer #(
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned GUARD_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_go,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  input  logic [WIDTH-1:0] gcd_out,
  input  logic             gcd_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_gcd,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic             res_err,
  output logic             busy,
  output logic [15:0]      job_count
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned GW   = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StGuard, StWait, StOut} state_e;

  logic [WIDTH-1:0] fifo_a_q [DEPTH];
  logic [WIDTH-1:0] fifo_b_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;
  logic [WIDTH-1:0] head_a, head_b;

  state_e           state_q, state_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic             gcd_go_q, gcd_go_d;
  logic [WIDTH-1:0] gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_gcd_q, res_gcd_d, res_a_q, res_a_d, res_b_q, res_b_d;
  logic [15:0]      job_count_q, job_count_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             res_err_q, res_err_d;
`endif

  // in_ready is registered, so a full FIFO never accepts even while popping.
  assign push   = in_valid && in_ready_q;
  assign pop    = (state_q == StIdle) && (cnt_q != '0);
  assign head_a = fifo_a_q[rd_ptr_q];
  assign head_b = fifo_b_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= in_a;
      fifo_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    gcd_go_d    = 1'b0;
    gcd_a_d     = gcd_a_q;
    gcd_b_d     = gcd_b_q;
    res_valid_d = res_valid_q;
    res_gcd_d   = res_gcd_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
    job_count_d = job_count_q;
`ifdef GCD_SEQ_TIMEOUT_EN
    tmo_d       = '0;
    res_err_d   = res_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          gcd_a_d = head_a;
          gcd_b_d = head_b;
          res_a_d = head_a;
          res_b_d = head_b;
          // A zero operand makes the answer the other operand; the core is skipped.
          if (head_a == '0 || head_b == '0) begin
            res_gcd_d   = head_a | head_b;
            res_valid_d = 1'b1;
            state_d     = StOut;
          end else begin
            gcd_go_d = 1'b1;
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        guard_d = GW'(GUARD_CYC);
        state_d = (GUARD_CYC == 0) ? StWait : StGuard;
      end
      StGuard: begin
        guard_d = guard_q - GW'(1);
        if (guard_d == '0) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (gcd_done) begin
          res_gcd_d   = gcd_out;
          res_valid_d = 1'b1;
          state_d     = StOut;
`ifdef GCD_SEQ_TIMEOUT_EN
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          res_gcd_d   = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = StOut;
        end else begin
          tmo_d = tmo_q + TW'(1);
`endif
        end
      end
      StOut: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          job_count_d = job_count_q + 16'd1;
          state_d     = StIdle;
`ifdef GCD_SEQ_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d     = (state_d != StIdle) || (cnt_d != '0);
    in_ready_d = (cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= StIdle;
      guard_q     <= '0;
      gcd_go_q    <= 1'b0;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_gcd_q   <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      job_count_q <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef GCD_SEQ_TIMEOUT_EN
      tmo_q       <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      guard_q     <= guard_d;
      gcd_go_q    <= gcd_go_d;
      gcd_a_q     <= gcd_a_d;
      gcd_b_q     <= gcd_b_d;
      res_valid_q <= res_valid_d;
      res_gcd_q   <= res_gcd_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      job_count_q <= job_count_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
`ifdef GCD_SEQ_TIMEOUT_EN
      tmo_q       <= tmo_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign gcd_go    = gcd_go_q;
  assign gcd_a     = gcd_a_q;
  assign gcd_b     = gcd_b_q;
  assign res_valid = res_valid_q;
  assign res_gcd   = res_gcd_q;
  assign res_a     = res_a_q;
  assign res_b     = res_b_q;
  assign busy      = busy_q;
  assign job_count = job_count_q;
`ifdef GCD_SEQ_TIMEOUT_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural top_gcd core model.
`timescale 1ns/1ps
module tb_gcd_job_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, res_ready = 1'b0;
  logic [6:0] in_a = '0, in_b = '0;
  logic       in_ready, gcd_go, res_valid, res_err, busy;
  logic [6:0] gcd_a, gcd_b, res_gcd, res_a, res_b;
  logic [6:0] gcd_out = '0;
  logic       gcd_done = 1'b0;
  logic [15:0] job_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gcd_job_sequencer #(.WIDTH(7), .DEPTH(4), .GUARD_CYC(2), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .gcd_go(gcd_go), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_out(gcd_out), .gcd_done(gcd_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_gcd(res_gcd), .res_a(res_a),
    .res_b(res_b), .res_err(res_err), .busy(busy), .job_count(job_count)
  );

  // Core model: done drops the cycle after go is seen, result arrives a few cycles later
  // and done then stays high until the next go, like the real core.
  logic       core_mute = 1'b0;
  int         m_cnt = 0;
  logic [6:0] m_res = '0;
  int         go_pulses = 0;
  logic [6:0] go_a = '0, go_b = '0;

  function automatic logic [6:0] euclid(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  always @(posedge clk) begin
    if (gcd_go) begin
      go_pulses <= go_pulses + 1;
      go_a      <= gcd_a;
      go_b      <= gcd_b;
      m_cnt     <= 4;
      m_res     <= euclid(gcd_a, gcd_b);
    end else if (core_mute) begin
      gcd_done <= 1'b0;
      m_cnt    <= 0;
    end else if (m_cnt != 0) begin
      m_cnt    <= m_cnt - 1;
      gcd_done <= (m_cnt == 1);
      if (m_cnt == 1) gcd_out <= m_res;
    end
  end

  // Result scoreboard: every handshaken result in arrival order.
  logic [6:0] q_gcd[$], q_a[$], q_b[$];
  logic       q_err[$];

  always @(posedge clk) begin
    if (rst && res_valid && res_ready) begin
      q_gcd.push_back(res_gcd);
      q_a.push_back(res_a);
      q_b.push_back(res_b);
      q_err.push_back(res_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  task automatic push(input logic [6:0] a, input logic [6:0] b);
    int k;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    k = 0;
    while (!in_ready && k < 100) begin
      tick(1);
      k++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL push_accept a=%0d b=%0d in_ready=%b want=1", a, b, in_ready);
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input string name);
    int k;
    k = 0;
    while (q_gcd.size() < target && k < 500) begin
      tick(1);
      k++;
    end
    checks++;
    if (q_gcd.size() < target) begin
      failures++;
      $display("FAIL %s results=%0d want=%0d", name, q_gcd.size(), target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    checks++; if (gcd_go !== 1'b0) begin failures++; $display("FAIL reset_gcd_go got=%b want=0", gcd_go); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (job_count !== 16'd0) begin failures++; $display("FAIL reset_job_count got=%0d want=0", job_count); end
    checks++; if ({res_gcd, res_a, res_b, gcd_a, gcd_b} !== 35'd0) begin failures++; $display("FAIL reset_data got=%h want=0", {res_gcd, res_a, res_b, gcd_a, gcd_b}); end
    checks++; if (res_err !== 1'b0) begin failures++; $display("FAIL reset_res_err got=%b want=0", res_err); end
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_single_job();
    int base, g0;
    base = q_gcd.size();
    g0 = go_pulses;
    res_ready = 1'b1;
    push(7'd35, 7'd21);
    wait_results(base + 1, "single_wait");
    if (q_gcd.size() > base) begin
      checks++; if (q_gcd[base] !== 7'd7) begin failures++; $display("FAIL single_gcd got=%0d want=7", q_gcd[base]); end
      checks++; if (q_a[base] !== 7'd35 || q_b[base] !== 7'd21) begin failures++; $display("FAIL single_echo got=%0d,%0d want=35,21", q_a[base], q_b[base]); end
      checks++; if (q_err[base] !== 1'b0) begin failures++; $display("FAIL single_err got=%b want=0", q_err[base]); end
    end
    checks++; if (go_pulses - g0 != 1) begin failures++; $display("FAIL single_go_pulses got=%0d want=1", go_pulses - g0); end
    checks++; if (go_a !== 7'd35 || go_b !== 7'd21) begin failures++; $display("FAIL single_core_operands got=%0d,%0d want=35,21", go_a, go_b); end
    checks++; if (job_count !== 16'd1) begin failures++; $display("FAIL single_job_count got=%0d want=1", job_count); end
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL single_idle busy=%b res_valid=%b want=0,0", busy, res_valid); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] va[6], vb[6], want[6];
    logic       acc[6];
    int base, n_acc;
    va = '{7'd35, 7'd56, 7'd12, 7'd17, 7'd9, 7'd8};
    vb = '{7'd21, 7'd98, 7'd18, 7'd5, 7'd6, 7'd4};
    want = '{7'd7, 7'd14, 7'd6, 7'd1, 7'd3, 7'd4};
    do_reset();
    res_ready = 1'b0;
    base = q_gcd.size();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
      acc[i] = in_ready;
      if (in_ready) n_acc++;
      tick(1);
    end
    in_valid = 1'b0;
    checks++; if (n_acc != 5) begin failures++; $display("FAIL b2b_accepted got=%0d want=5", n_acc); end
    checks++; if (acc[5] !== 1'b0) begin failures++; $display("FAIL b2b_sixth_in_ready got=%b want=0", acc[5]); end
    res_ready = 1'b1;
    push(va[5], vb[5]);
    wait_results(base + 6, "b2b_wait");
    for (int i = 0; i < 6; i++) begin
      if (q_gcd.size() > base + i) begin
        checks++;
        if (q_gcd[base+i] !== want[i] || q_a[base+i] !== va[i]) begin
          failures++;
          $display("FAIL b2b_result%0d got=%0d(a=%0d) want=%0d(a=%0d)", i, q_gcd[base+i], q_a[base+i], want[i], va[i]);
        end
      end
    end
    tick(1);
    checks++; if (job_count !== 16'd6) begin failures++; $display("FAIL b2b_job_count got=%0d want=6", job_count); end
  endtask

  task automatic test_bypass();
    int base, g0, n;
    base = q_gcd.size();
    g0 = go_pulses;
    res_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 7'd0;
    in_b = 7'd9;
    tick(1);
    in_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 10) begin
      tick(1);
      n++;
    end
    checks++; if (n != 2) begin failures++; $display("FAIL bypass_latency got=%0d want=2", n); end
    push(7'd0, 7'd0);
    wait_results(base + 2, "bypass_wait");
    if (q_gcd.size() >= base + 2) begin
      checks++; if (q_gcd[base] !== 7'd9) begin failures++; $display("FAIL bypass_0_9 got=%0d want=9", q_gcd[base]); end
      checks++; if (q_gcd[base+1] !== 7'd0) begin failures++; $display("FAIL bypass_0_0 got=%0d want=0", q_gcd[base+1]); end
      checks++; if (q_b[base] !== 7'd9) begin failures++; $display("FAIL bypass_echo_b got=%0d want=9", q_b[base]); end
    end
    checks++; if (go_pulses != g0) begin failures++; $display("FAIL bypass_no_go got=%0d want=0", go_pulses - g0); end
  endtask

  task automatic test_stale_done();
    int base;
    base = q_gcd.size();
    res_ready = 1'b1;
    push(7'd35, 7'd21);
    wait_results(base + 1, "stale_first_wait");
    push(7'd12, 7'd18);
    wait_results(base + 2, "stale_wait");
    if (q_gcd.size() >= base + 2) begin
      checks++; if (q_gcd[base] !== 7'd7) begin failures++; $display("FAIL stale_first got=%0d want=7", q_gcd[base]); end
      checks++; if (q_gcd[base+1] !== 7'd6) begin failures++; $display("FAIL stale_masked got=%0d want=6", q_gcd[base+1]); end
    end
  endtask

  task automatic test_reset_in_flight();
    int base, g0, k;
    core_mute = 1'b1;
    res_ready = 1'b1;
    push(7'd10, 7'd4);
    push(7'd9, 7'd6);
    push(7'd8, 7'd4);
    k = 0;
    while (go_pulses == 0 && k < 0) k++;
    tick(6);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rif_busy_before got=%b want=1", busy); end
    base = q_gcd.size();
    rst = 1'b0;
    tick(1);
    checks++; if (res_valid !== 1'b0 || gcd_go !== 1'b0) begin failures++; $display("FAIL rif_outputs res_valid=%b gcd_go=%b want=0,0", res_valid, gcd_go); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rif_status in_ready=%b busy=%b want=1,0", in_ready, busy); end
    checks++; if (job_count !== 16'd0) begin failures++; $display("FAIL rif_job_count got=%0d want=0", job_count); end
    rst = 1'b1;
    g0 = go_pulses;
    core_mute = 1'b0;
    tick(40);
    checks++; if (q_gcd.size() != base || res_valid !== 1'b0) begin failures++; $display("FAIL rif_no_results got=%0d valid=%b want=0,0", q_gcd.size() - base, res_valid); end
    checks++; if (go_pulses != g0 || busy !== 1'b0) begin failures++; $display("FAIL rif_quiet go=%0d busy=%b want=0,0", go_pulses - g0, busy); end
  endtask

  task automatic test_timeout();
    int k, n;
    core_mute = 1'b1;
    res_ready = 1'b0;
    push(7'd10, 7'd4);
`ifdef GCD_SEQ_TIMEOUT_EN
    k = 0;
    while (!gcd_go && k < 20) begin
      tick(1);
      k++;
    end
    n = 0;
    while (!res_valid && n < 400) begin
      tick(1);
      n++;
    end
    checks++; if (n != 258) begin failures++; $display("FAIL timeout_latency got=%0d want=258", n); end
    checks++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_gcd !== 7'd0) begin failures++; $display("FAIL timeout_result valid=%b err=%b gcd=%0d want=1,1,0", res_valid, res_err, res_gcd); end
    checks++; if (res_a !== 7'd10 || res_b !== 7'd4) begin failures++; $display("FAIL timeout_echo got=%0d,%0d want=10,4", res_a, res_b); end
    res_ready = 1'b1;
    tick(1);
    checks++; if (res_err !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL timeout_clear err=%b valid=%b want=0,0", res_err, res_valid); end
`else
    k = 0;
    n = 0;
    tick(300 + k + n);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL no_timeout_busy got=%b want=1", busy); end
    checks++; if (res_valid !== 1'b0 || res_err !== 1'b0) begin failures++; $display("FAIL no_timeout_valid valid=%b err=%b want=0,0", res_valid, res_err); end
`endif
    core_mute = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_bypass();
    test_stale_done();
    test_reset_in_flight();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
